pixel_mem_responder: RTL and testbench
======================================

Name: pixel_mem_responder

Overview:
- Memory-side responder for the receptive-field pixel-fetch interface.
- Owns an on-chip image store, loaded through a write port.
- Samples the pixel address driven by the receptive field and returns mem_word with a one-cycle data_valid pulse.
- Pulses addr_clear to restart a pass, tracks which image the requester is on by watching the address, and stops after NUM_IMGS images.

Parameters:
- ADDR_BITS, `MEM_ADDR_BITS: width of the pixel address.
- WORD_BITS, `MEM_WORD_BITS: width of one stored word; one word holds one pixel.
- IMG_HEIGHT, `IMG_HEIGHT: image rows.
- IMG_WIDTH, `IMG_WIDTH: image columns.
- NUM_IMGS, 4: images held in the store.
- Derived localparams: IMG_SIZE = IMG_HEIGHT*IMG_WIDTH; MEM_DEPTH = NUM_IMGS*IMG_SIZE.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a pass; sampled in IDLE or DONE, ignored otherwise.
- stall  in  1  memory not available this cycle; holds the fetch.
- addr  in  ADDR_BITS  pixel address from the requester.
- mem_word  out  WORD_BITS  returned pixel word.
- data_valid  out  1  mem_word valid for the address sampled in the previous cycle.
- addr_clear  out  1  one-cycle pulse; requester reloads its init address.
- wr_en  in  1  store write enable.
- wr_addr  in  ADDR_BITS  store write address.
- wr_data  in  WORD_BITS  store write data.
- busy  out  1  high in CLR, REQ and RESP.
- done  out  1  high in DONE.
- img_idx  out  $clog2(NUM_IMGS+1)  index of the image currently being served.
- addr_err  out  1  sticky: a sampled address fell below the current image base.

Behaviour:
- Interface fact: clk; rst is synchronous, active-high. All state changes occur on posedge clk.
- Reset values:
  - state = IDLE.
  - mem_word = 0, data_valid = 0, addr_clear = 0, busy = 0, done = 0, img_idx = 0, addr_err = 0.
  - img_base = 0.
  - Store contents are not reset.
- FSM states: IDLE, CLR, REQ, RESP, DONE.
- IDLE: start=1 -> CLR.
- CLR:
  - addr_clear=1 for exactly this cycle.
  - img_idx <= 0, img_base <= 0, addr_err <= 0.
  - Next state REQ. The requester's address register holds its init address from the REQ cycle onward.
- REQ: samples addr.
  - stall=1: stay in REQ, no sample.
  - addr >= img_base+IMG_SIZE: the requester has moved to the next image. Set img_idx+1 and img_base+IMG_SIZE. If the new img_idx == NUM_IMGS, go to DONE with no read. Otherwise stay in REQ one cycle with no read, and re-check against the new base next cycle.
  - addr < img_base: set addr_err, then treat the request as a normal read.
  - Normal read: rdata <= store[addr], then go to RESP. An address >= MEM_DEPTH reads 0.
- RESP:
  - data_valid=1, mem_word=rdata for exactly one cycle; next state REQ.
  - mem_word holds its last value while data_valid=0.
- Throughput: at most one response per 2 cycles. This is required because the requester advances its address on the edge after data_valid; the responder must not validate the stale address.
- Requester waiting on its downstream: the address is held, so the responder keeps re-serving the same pixel every 2 cycles. This is legal and harmless.
- DONE:
  - done=1, data_valid=0.
  - start=1 -> CLR (restart).
- Write port:
  - Active in every state.
  - wr_addr >= MEM_DEPTH is ignored.
  - Same-cycle read and write of one address: the read returns the old data (read-before-write).
- start outside IDLE/DONE: ignored.
- rst during any state: next cycle matches the reset values; an in-flight response is dropped.
- Width rules:
  - img_base and comparisons use ADDR_BITS+1 bits so img_base+IMG_SIZE cannot overflow.
  - MEM_DEPTH must fit in 2^ADDR_BITS; checked by an elaboration assertion.

Decomposition:
- Shared package (internal_defines companion):
  - Typedef for the FSM state enum (IDLE, CLR, REQ, RESP, DONE).
  - Constants IMG_SIZE and MEM_DEPTH.
- One sub-module, pixel_store: a MEM_DEPTH x WORD_BITS synchronous single-read/single-write array with read-before-write and out-of-range read returning 0.
- FSM, image tracking and output registers stay in the top module.

Test Plan:
Bench parameters: IMG_HEIGHT=IMG_WIDTH=4, NUM_IMGS=2, WORD_BITS=8, ADDR_BITS=8; store[i] = i+1.
1. Reset, then start=1 with addr driven at 5 -> addr_clear high exactly in cycle 1. REQ samples 5 in cycle 2. Cycle 3 gives data_valid=1, mem_word=6. data_valid is never high two cycles in a row.
2. Stall: hold stall=1 for 3 cycles in REQ with addr=7 -> no data_valid during the stall. data_valid=1 with mem_word=8 exactly 1 cycle after stall drops.
3. Image advance: addr moves from 15 to 21 -> img_idx goes 0->1, then the response carries mem_word=22. Next, addr moves from 31 to 37 -> done=1, data_valid stays 0, busy=0.
4. Write collision: in a REQ cycle, addr=3 and wr_en=1 with wr_addr=3, wr_data=0xAA -> response mem_word=4. A later read of 3 returns 0xAA.
5. Errors: after img_idx=1, drive addr=2 -> addr_err latches 1 and the response is mem_word=3. A restart via start clears addr_err.
6. Mid-operation reset: assert rst in RESP -> next cycle data_valid=0, state IDLE, img_idx=0, and store contents are preserved (a re-read of addr 5 returns 6).

Source files
------------

// File: rtl/pixel_mem_responder_pkg.sv
// Shared types and sizing helpers for the pixel-fetch memory responder.
package pixel_mem_responder_pkg;

   // Default configuration used when the top is instantiated without overrides.
   localparam int unsigned DEF_ADDR_BITS  = 8;
   localparam int unsigned DEF_WORD_BITS  = 8;
   localparam int unsigned DEF_IMG_HEIGHT = 4;
   localparam int unsigned DEF_IMG_WIDTH  = 4;
   localparam int unsigned DEF_NUM_IMGS   = 4;

   localparam int unsigned IMG_SIZE  = DEF_IMG_HEIGHT * DEF_IMG_WIDTH;
   localparam int unsigned MEM_DEPTH = DEF_NUM_IMGS * IMG_SIZE;

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StReq,
      StResp,
      StDone
   } state_e;

   function automatic int unsigned img_size(input int unsigned height, input int unsigned width);
      return height * width;
   endfunction

   function automatic int unsigned mem_depth(input int unsigned num_imgs,
                                             input int unsigned height,
                                             input int unsigned width);
      return num_imgs * height * width;
   endfunction

endpackage

// File: rtl/pixel_store.sv
// On-chip image store: one synchronous read port, one write port.
// Reads return the pre-write contents on a same-address collision.
module pixel_store #(
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned WORD_BITS = 8,
   parameter int unsigned DEPTH     = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_en,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [WORD_BITS-1:0] rd_data,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [WORD_BITS-1:0] wr_data
);

   localparam int unsigned IdxBits = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned Aw1     = ADDR_BITS + 1;
   localparam logic [Aw1-1:0] DepthW = Aw1'(DEPTH);

   logic [WORD_BITS-1:0] mem [DEPTH];
   logic                 rd_in_range;
   logic                 wr_in_range;

   assign rd_in_range = ({1'b0, rd_addr} < DepthW);
   assign wr_in_range = ({1'b0, wr_addr} < DepthW);

   // Read register; out-of-range addresses read as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= rd_in_range ? mem[rd_addr[IdxBits-1:0]] : '0;
      end
   end

   // Array write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en && wr_in_range) begin
         mem[wr_addr[IdxBits-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/pixel_mem_responder.sv
// Memory-side responder for the receptive-field pixel fetch: serves one pixel
// per two cycles, tracks the requester's current image from its address and
// stops after the last image.
module pixel_mem_responder
   import pixel_mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
   parameter int unsigned WORD_BITS  = DEF_WORD_BITS,
   parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int unsigned NUM_IMGS   = DEF_NUM_IMGS
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              stall,
   input  logic [ADDR_BITS-1:0]              addr,
   output logic [WORD_BITS-1:0]              mem_word,
   output logic                              data_valid,
   output logic                              addr_clear,
   input  logic                              wr_en,
   input  logic [ADDR_BITS-1:0]              wr_addr,
   input  logic [WORD_BITS-1:0]              wr_data,
   output logic                              busy,
   output logic                              done,
   output logic [$clog2(NUM_IMGS+1)-1:0]     img_idx,
   output logic                              addr_err
);

   localparam int unsigned ImgSize  = img_size(IMG_HEIGHT, IMG_WIDTH);
   localparam int unsigned MemDepth = mem_depth(NUM_IMGS, IMG_HEIGHT, IMG_WIDTH);
   localparam int unsigned IdxBits  = $clog2(NUM_IMGS + 1);
   localparam int unsigned Aw1      = ADDR_BITS + 1;
   localparam logic [Aw1-1:0]     ImgSizeW = Aw1'(ImgSize);
   localparam logic [IdxBits-1:0] LastIdx  = IdxBits'(NUM_IMGS);

   if ($clog2(MemDepth) > ADDR_BITS) begin : g_depth_check
      $error("pixel_mem_responder: store depth does not fit in the address width");
   end

   state_e               state_q, state_d;
   logic [IdxBits-1:0]   img_idx_q, img_idx_d;
   logic [Aw1-1:0]       img_base_q, img_base_d;
   logic                 addr_err_q, addr_err_d;
   logic                 rd_en;
   logic [Aw1-1:0]       addr_ext;
   logic [Aw1-1:0]       base_end;
   logic [IdxBits-1:0]   idx_inc;

   // Extra top bit keeps base + image size from wrapping.
   assign addr_ext = {1'b0, addr};
   assign base_end = img_base_q + ImgSizeW;
   assign idx_inc  = img_idx_q + IdxBits'(1);

   // Next-state, image tracking and read-issue decode.
   always_comb begin
      state_d    = state_q;
      img_idx_d  = img_idx_q;
      img_base_d = img_base_q;
      addr_err_d = addr_err_q;
      rd_en      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StClr;
         end
         StClr: begin
            img_idx_d  = '0;
            img_base_d = '0;
            addr_err_d = 1'b0;
            state_d    = StReq;
         end
         StReq: begin
            if (!stall) begin
               if (addr_ext >= base_end) begin
                  // Requester moved to the next image: rebase, re-check next cycle.
                  img_idx_d  = idx_inc;
                  img_base_d = base_end;
                  if (idx_inc == LastIdx) state_d = StDone;
               end else begin
                  if (addr_ext < img_base_q) addr_err_d = 1'b1;
                  rd_en   = 1'b1;
                  state_d = StResp;
               end
            end
         end
         StResp: begin
            state_d = StReq;
         end
         StDone: begin
            if (start) state_d = StClr;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and image-tracking registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         img_idx_q  <= '0;
         img_base_q <= '0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         img_idx_q  <= img_idx_d;
         img_base_q <= img_base_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign data_valid = (state_q == StResp);
   assign addr_clear = (state_q == StClr);
   assign busy       = (state_q == StClr) || (state_q == StReq) || (state_q == StResp);
   assign done       = (state_q == StDone);
   assign img_idx    = img_idx_q;
   assign addr_err   = addr_err_q;

   // Read data register doubles as mem_word; it only changes on an issued read.
   pixel_store #(
      .ADDR_BITS (ADDR_BITS),
      .WORD_BITS (WORD_BITS),
      .DEPTH     (MemDepth)
   ) u_store (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (rd_en),
      .rd_addr (addr),
      .rd_data (mem_word),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

endmodule

// File: tb/tb_pixel_mem_responder.sv
// Directed, table-driven bench for pixel_mem_responder (4x4 images, 2 images).
module tb_pixel_mem_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stall = 1'b0;
   logic [7:0] addr = '0;
   logic [7:0] mem_word;
   logic       data_valid;
   logic       addr_clear;
   logic       wr_en = 1'b0;
   logic [7:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       busy;
   logic       done;
   logic [1:0] img_idx;
   logic       addr_err;

   int n_tests = 0;
   int n_fail  = 0;
   logic dv_prev = 1'b0;

   always #5 clk = ~clk;

   pixel_mem_responder #(
      .ADDR_BITS  (8),
      .WORD_BITS  (8),
      .IMG_HEIGHT (4),
      .IMG_WIDTH  (4),
      .NUM_IMGS   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stall      (stall),
      .addr       (addr),
      .mem_word   (mem_word),
      .data_valid (data_valid),
      .addr_clear (addr_clear),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .img_idx    (img_idx),
      .addr_err   (addr_err)
   );

   typedef struct {
      logic       start;
      logic       stall;
      logic [7:0] addr;
      logic       we;
      logic [7:0] wa;
      logic [7:0] wd;
      logic       dv;
      logic [7:0] word;
      logic       clr;
      logic       busy;
      logic       done;
      logic [1:0] idx;
      logic       err;
   } vec_t;

   localparam int NVec = 27;
   vec_t vecs[NVec];

   function automatic vec_t mk(input logic st, input logic sl, input logic [7:0] a,
                               input logic we, input logic [7:0] wa, input logic [7:0] wd,
                               input logic dv, input logic [7:0] w, input logic clr,
                               input logic bz, input logic dn, input logic [1:0] ix,
                               input logic er);
      vec_t v;
      v.start = st; v.stall = sl; v.addr = a; v.we = we; v.wa = wa; v.wd = wd;
      v.dv = dv; v.word = w; v.clr = clr; v.busy = bz; v.done = dn; v.idx = ix; v.err = er;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Packed order: dv, word, clr, busy, done, idx, err.
   task automatic check(input string name, input logic [14:0] exp);
      logic [14:0] act;
      act = {data_valid, mem_word, addr_clear, busy, done, img_idx, addr_err};
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got dv=%b word=%h clr=%b busy=%b done=%b idx=%0d err=%b, expected dv=%b word=%h clr=%b busy=%b done=%b idx=%0d err=%b",
                  name, act[14], act[13:6], act[5], act[4], act[3], act[2:1], act[0],
                  exp[14], exp[13:6], exp[5], exp[4], exp[3], exp[2:1], exp[0]);
      end
   endtask

   // data_valid must never be high on two consecutive cycles.
   always @(negedge clk) begin
      if (dv_prev) begin
         n_tests++;
         if (data_valid) begin
            n_fail++;
            $display("FAIL dv_back_to_back: got data_valid=1 expected 0 at %0t", $time);
         end
      end
      dv_prev = data_valid;
   end

   initial begin
      //            st sl addr we wa wd    dv word   clr bz dn idx er
      vecs[0]  = mk(1, 0, 5,  0, 0, 0,    0, 8'h00, 1, 1, 0, 0, 0);
      vecs[1]  = mk(0, 0, 5,  0, 0, 0,    0, 8'h00, 0, 1, 0, 0, 0);
      vecs[2]  = mk(0, 0, 5,  0, 0, 0,    1, 8'h06, 0, 1, 0, 0, 0);
      vecs[3]  = mk(0, 1, 7,  0, 0, 0,    0, 8'h06, 0, 1, 0, 0, 0);
      vecs[4]  = mk(1, 1, 7,  0, 0, 0,    0, 8'h06, 0, 1, 0, 0, 0);
      vecs[5]  = mk(0, 1, 7,  0, 0, 0,    0, 8'h06, 0, 1, 0, 0, 0);
      vecs[6]  = mk(0, 1, 7,  0, 0, 0,    0, 8'h06, 0, 1, 0, 0, 0);
      vecs[7]  = mk(0, 0, 7,  0, 0, 0,    1, 8'h08, 0, 1, 0, 0, 0);
      vecs[8]  = mk(0, 0, 15, 0, 0, 0,    0, 8'h08, 0, 1, 0, 0, 0);
      vecs[9]  = mk(0, 0, 15, 0, 0, 0,    1, 8'h10, 0, 1, 0, 0, 0);
      vecs[10] = mk(0, 0, 21, 0, 0, 0,    0, 8'h10, 0, 1, 0, 0, 0);
      vecs[11] = mk(0, 0, 21, 0, 0, 0,    0, 8'h10, 0, 1, 0, 1, 0);
      vecs[12] = mk(0, 0, 21, 0, 0, 0,    1, 8'h16, 0, 1, 0, 1, 0);
      vecs[13] = mk(0, 0, 2,  0, 0, 0,    0, 8'h16, 0, 1, 0, 1, 0);
      vecs[14] = mk(0, 0, 2,  0, 0, 0,    1, 8'h03, 0, 1, 0, 1, 1);
      vecs[15] = mk(0, 0, 3,  0, 0, 0,    0, 8'h03, 0, 1, 0, 1, 1);
      vecs[16] = mk(0, 0, 3,  1, 3, 8'hAA, 1, 8'h04, 0, 1, 0, 1, 1);
      vecs[17] = mk(0, 0, 3,  0, 0, 0,    0, 8'h04, 0, 1, 0, 1, 1);
      vecs[18] = mk(0, 0, 3,  0, 0, 0,    1, 8'hAA, 0, 1, 0, 1, 1);
      vecs[19] = mk(0, 0, 31, 0, 0, 0,    0, 8'hAA, 0, 1, 0, 1, 1);
      vecs[20] = mk(0, 0, 31, 0, 0, 0,    1, 8'h20, 0, 1, 0, 1, 1);
      vecs[21] = mk(0, 0, 37, 0, 0, 0,    0, 8'h20, 0, 1, 0, 1, 1);
      vecs[22] = mk(0, 0, 37, 0, 0, 0,    0, 8'h20, 0, 0, 1, 2, 1);
      vecs[23] = mk(0, 0, 37, 0, 0, 0,    0, 8'h20, 0, 0, 1, 2, 1);
      vecs[24] = mk(1, 0, 5,  0, 0, 0,    0, 8'h20, 1, 1, 0, 2, 1);
      vecs[25] = mk(0, 0, 5,  0, 0, 0,    0, 8'h20, 0, 1, 0, 0, 0);
      vecs[26] = mk(0, 0, 5,  0, 0, 0,    1, 8'h06, 0, 1, 0, 0, 0);

      // Reset state.
      rst = 1'b1;
      tick();
      tick();
      check("reset_state", 15'h0000);
      rst = 1'b0;
      tick();
      check("idle_after_reset", 15'h0000);

      // Preload store[i] = i+1; one out-of-range write must be dropped silently.
      for (int i = 0; i < 32; i++) begin
         wr_en   = 1'b1;
         wr_addr = 8'(i);
         wr_data = 8'(i + 1);
         tick();
      end
      wr_addr = 8'd40;
      wr_data = 8'h55;
      tick();
      wr_en = 1'b0;
      check("idle_after_preload", 15'h0000);

      // Main cycle-by-cycle sequence.
      for (int k = 0; k < NVec; k++) begin
         start   = vecs[k].start;
         stall   = vecs[k].stall;
         addr    = vecs[k].addr;
         wr_en   = vecs[k].we;
         wr_addr = vecs[k].wa;
         wr_data = vecs[k].wd;
         tick();
         check($sformatf("row%0d", k),
               {vecs[k].dv, vecs[k].word, vecs[k].clr, vecs[k].busy, vecs[k].done,
                vecs[k].idx, vecs[k].err});
      end
      start = 1'b0;
      wr_en = 1'b0;

      // Reset while a response is on the bus drops it and returns to idle.
      rst = 1'b1;
      tick();
      check("reset_in_resp", 15'h0000);
      rst = 1'b0;

      // Store survives reset: restart and re-read address 5.
      start = 1'b1;
      addr  = 8'd5;
      tick();
      check("restart_clr", {1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0});
      start = 1'b0;
      tick();
      check("restart_req", {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0});
      tick();
      check("reread_after_reset", {1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0});
      tick();
      check("req_after_reread", {1'b0, 8'h06, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
